// File: rtl/matinv_pkg.sv
// Shared widths, FSM state encoding and response payload for the matrix-inverse scheduler.
package matinv_pkg;

  localparam int unsigned MAT_W   = 512;
  localparam int unsigned ELEM_W  = 32;
  localparam int unsigned FRAC_W  = 12;
  localparam int unsigned ENG_LAT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAT_W-1:0] mat;
    logic             singular;
    logic             timeout;
  } rsp_payload_t;

  // A singular input makes the engine return an all-zero matrix.
  function automatic logic mat_is_zero(input logic [MAT_W-1:0] m);
    return ~|m;
  endfunction

endpackage

// File: rtl/matinv_rr_arb.sv
// Combinational round-robin pick: first requester after ptr (wrapping) wins.
module matinv_rr_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NREQ);
      if (!found && req_vec[cand]) begin
        found            = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/matinv_sched.sv
// Round-robin scheduler sharing one 4x4 matrix-inverse engine among NREQ requesters,
// with start/done handshake, response channel and a hung-engine watchdog.
module matinv_sched
  import matinv_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*MAT_W-1:0]   req_mat,
  output logic                    rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [MAT_W-1:0]        rsp_mat,
  output logic                    rsp_singular,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    eng_start,
  output logic [MAT_W-1:0]        eng_ain,
  input  logic [MAT_W-1:0]        eng_bout,
  input  logic                    eng_done,
  output logic                    eng_rst
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eng_start_q, eng_start_d;
  logic [MAT_W-1:0] eng_ain_q, eng_ain_d;
  rsp_payload_t     rsp_q, rsp_d;
  logic             abort_q, abort_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic             grant_ok;
  logic [MAT_W-1:0] sel_mat;

  matinv_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_vec    (req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  // Wait for the engine's done to drop from the previous job before granting.
  assign grant_ok  = (state_q == ST_IDLE) && !eng_done && !rst;
  assign req_ready = grant_ok ? gnt_onehot : '0;

  always_comb begin
    sel_mat = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_onehot[k]) sel_mat = req_mat[k*MAT_W +: MAT_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    cnt_d       = cnt_q;
    eng_start_d = eng_start_q;
    eng_ain_d   = eng_ain_q;
    rsp_d       = rsp_q;
    abort_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_ok && (|gnt_onehot)) begin
          eng_ain_d   = sel_mat;
          eng_start_d = 1'b1;
          rsp_id_d    = gnt_idx;
          ptr_d       = gnt_idx;
          cnt_d       = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (eng_done) begin
          rsp_d.mat      = eng_bout;
          rsp_d.singular = mat_is_zero(eng_bout);
          rsp_d.timeout  = 1'b0;
          eng_start_d    = 1'b0;
          state_d        = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Watchdog: drop start and pulse the engine reset for one cycle.
          eng_start_d    = 1'b0;
          abort_d        = 1'b1;
          rsp_d.mat      = '0;
          rsp_d.singular = 1'b0;
          rsp_d.timeout  = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[rsp_id_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NREQ - 1);
      rsp_id_q    <= '0;
      cnt_q       <= '0;
      eng_start_q <= 1'b0;
      eng_ain_q   <= '0;
      rsp_q       <= '0;
      abort_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
      eng_start_q <= eng_start_d;
      eng_ain_q   <= eng_ain_d;
      rsp_q       <= rsp_d;
      abort_q     <= abort_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign eng_start    = eng_start_q;
  assign eng_ain      = eng_ain_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_mat      = rsp_q.mat;
  assign rsp_singular = rsp_q.singular;
  assign rsp_timeout  = rsp_q.timeout;
  assign busy         = busy_q;
  assign eng_rst      = rst | abort_q;

endmodule

// File: tb/tb_matinv_sched.sv
// Scoreboard bench for matinv_sched with a behavioural engine that returns ~Ain, zero, or stalls.
module tb_matinv_sched;
  import matinv_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*MAT_W-1:0] req_mat = '0;
  logic                  rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic [IDX_W-1:0]      rsp_id;
  logic [MAT_W-1:0]      rsp_mat;
  logic                  rsp_singular, rsp_timeout, busy, eng_start;
  logic [MAT_W-1:0]      eng_ain, eng_bout;
  logic                  eng_done, eng_rst;

  matinv_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mat(req_mat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_mat(rsp_mat),
    .rsp_singular(rsp_singular), .rsp_timeout(rsp_timeout), .busy(busy),
    .eng_start(eng_start), .eng_ain(eng_ain), .eng_bout(eng_bout), .eng_done(eng_done),
    .eng_rst(eng_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] id;
    logic [MAT_W-1:0] mat;
    logic             sing;
    logic             tmo;
  } exp_rsp_t;

  exp_rsp_t exp_rsp_q[$];
  int       exp_gnt_q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_mat(input string name, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Engine model: mode 0 returns ~Ain, 1 returns zero, 2 never finishes.
  int               eng_mode = 0;
  logic [MAT_W-1:0] m_ain = '0, m_bout = '0;
  logic             m_done = 1'b0, m_st_d1 = 1'b0;
  int               m_k = 0;

  assign eng_done = m_done;
  assign eng_bout = m_bout;

  always @(posedge clk) begin
    if (eng_rst) begin
      m_done  <= 1'b0;
      m_k     <= 0;
      m_st_d1 <= 1'b0;
      m_bout  <= '0;
    end else begin
      m_st_d1 <= eng_start;
      if (eng_start) begin
        if (m_k == 0) m_ain <= eng_ain;
        if (m_k < int'(ENG_LAT)) m_k <= m_k + 1;
        if (m_k == int'(ENG_LAT) - 1 && eng_mode != 2) begin
          m_done <= 1'b1;
          m_bout <= (eng_mode == 1) ? '0 : ~m_ain;
        end
      end else begin
        m_k <= 0;
        if (!m_st_d1) m_done <= 1'b0;
      end
    end
  end

  int   last_gnt_cyc = 0;
  int   exp_lat = 0;
  bit   gap_chk = 1'b0, gap_armed = 1'b0;
  int   abort_cnt = 0;

  // Monitor: grants, response latency, abort pulses and response handshakes.
  initial begin
    logic     prev_rv;
    int       gi;
    exp_rsp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != '0) begin
          gi = 0;
          for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) gi = i;
          check("gnt_onehot", 32'($onehot(req_ready)), 32'(1));
          if (exp_gnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL gnt_unexpected: got req_ready %b expected none (cycle %0d)", req_ready, cyc);
          end else begin
            check("gnt_id", 32'(gi), 32'(exp_gnt_q.pop_front()));
          end
          if (gap_chk) begin
            if (gap_armed) check("gnt_gap", 32'(cyc - last_gnt_cyc), 32'(13));
            gap_armed = 1'b1;
          end
          last_gnt_cyc = cyc;
        end
        if (rsp_valid && !prev_rv && exp_lat != 0)
          check("rsp_lat", 32'(cyc - last_gnt_cyc), 32'(exp_lat));
        if (eng_rst) begin
          abort_cnt++;
          check("abort_rsp_valid", 32'(rsp_valid), 32'(1));
          check("abort_lat", 32'(cyc - last_gnt_cyc), 32'(TIMEOUT + 1));
        end
        if (rsp_valid && rsp_ready[rsp_id]) begin
          if (exp_rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d expected no response (cycle %0d)", rsp_id, cyc);
          end else begin
            e = exp_rsp_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check_mat("rsp_mat", rsp_mat, e.mat);
            check("rsp_singular", 32'(rsp_singular), 32'(e.sing));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mat(input int k, input logic [MAT_W-1:0] m);
    req_mat[k*MAT_W +: MAT_W] = m;
  endtask

  task automatic push_rsp(input int id, input logic [MAT_W-1:0] m, input logic s, input logic t);
    exp_rsp_t e;
    e.id   = IDX_W'(id);
    e.mat  = m;
    e.sing = s;
    e.tmo  = t;
    exp_rsp_q.push_back(e);
  endtask

  task automatic wait_gnts(input string name);
    for (int n = 0; n < 200; n++) begin
      tick();
      if (exp_gnt_q.size() == 0) return;
    end
    fail_timeout(name);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 300; n++) begin
      if (exp_rsp_q.size() == 0) return;
      tick();
    end
    fail_timeout(name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_eng_start", 32'(eng_start), 32'(0));
    check_mat("rst_eng_ain", eng_ain, '0);
    check_mat("rst_rsp_mat", rsp_mat, '0);
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_flags", 32'({rsp_singular, rsp_timeout}), 32'(0));
    check("rst_eng_rst", 32'(eng_rst), 32'(1));
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MAT_W-1:0] pat;
    logic [MAT_W-1:0] mats [NREQ];
    bit               seen;

    for (int k = 0; k < int'(NREQ); k++) mats[k] = {16{32'(32'h1111_1111 * (k + 1))}};

    do_reset();

    // Single requester 2, Q20.12 ones pattern.
    pat       = {16{32'h0000_1000}};
    rsp_ready = '1;
    exp_lat   = 11;
    set_mat(2, pat);
    exp_gnt_q.push_back(2);
    push_rsp(2, ~pat, 1'b0, 1'b0);
    req_valid[2] = 1'b1;
    wait_gnts("t1_gnt");
    req_valid = '0;
    drain("t1_rsp");

    // All four requesting from reset: order 0,1,2,3,0, 13 cycles apart.
    do_reset();
    for (int k = 0; k < int'(NREQ); k++) set_mat(k, mats[k]);
    gap_chk   = 1'b1;
    gap_armed = 1'b0;
    foreach (exp_gnt_q[i]) exp_gnt_q.delete(i);
    for (int k = 0; k < 5; k++) begin
      exp_gnt_q.push_back(k % 4);
      push_rsp(k % 4, ~mats[k % 4], 1'b0, 1'b0);
    end
    req_valid = '1;
    wait_gnts("t2_gnt");
    req_valid = '0;
    gap_chk   = 1'b0;
    drain("t2_rsp");

    // Engine returns zero: singular flag.
    eng_mode = 1;
    exp_gnt_q.push_back(1);
    push_rsp(1, '0, 1'b1, 1'b0);
    req_valid[1] = 1'b1;
    wait_gnts("t3_gnt");
    req_valid = '0;
    drain("t3_rsp");
    eng_mode = 0;

    // Owner withholds rsp_ready for 20 cycles while others assert it and requester 0 waits.
    rsp_ready = 4'b0111;
    exp_gnt_q.push_back(3);
    push_rsp(3, ~mats[3], 1'b0, 1'b0);
    req_valid = 4'b1000;
    wait_gnts("t4_gnt");
    req_valid = 4'b0001;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      seen = rsp_valid;
    end
    if (!seen) fail_timeout("t4_rsp_valid");
    for (int n = 0; n < 20; n++) begin
      tick();
      check("hold_rsp_valid", 32'(rsp_valid), 32'(1));
      check_mat("hold_rsp_mat", rsp_mat, ~mats[3]);
      check("hold_rsp_id", 32'(rsp_id), 32'(3));
      check("hold_req_ready", 32'(req_ready), 32'(0));
      check("hold_busy", 32'(busy), 32'(1));
    end
    exp_gnt_q.push_back(0);
    push_rsp(0, ~mats[0], 1'b0, 1'b0);
    rsp_ready = '1;
    wait_gnts("t4_gnt0");
    req_valid = '0;
    drain("t4_rsp");

    // Stalled engine: watchdog abort, then a normal job.
    eng_mode  = 2;
    abort_cnt = 0;
    exp_lat   = int'(TIMEOUT) + 1;
    exp_gnt_q.push_back(2);
    push_rsp(2, '0, 1'b0, 1'b1);
    req_valid[2] = 1'b1;
    wait_gnts("t5_gnt");
    req_valid = '0;
    drain("t5_rsp");
    check("abort_pulses", 32'(abort_cnt), 32'(1));
    eng_mode = 0;
    exp_lat  = 11;
    exp_gnt_q.push_back(1);
    push_rsp(1, ~mats[1], 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    wait_gnts("t5b_gnt");
    req_valid = '0;
    drain("t5b_rsp");
    check("abort_pulses_after", 32'(abort_cnt), 32'(1));

    // Reset mid-RUN: job dropped, requester 0 wins first after reset.
    exp_gnt_q.push_back(3);
    req_valid = 4'b1000;
    wait_gnts("t6_gnt");
    for (int n = 0; n < 4; n++) tick();
    check("t6_busy", 32'(busy), 32'(1));
    req_valid = 4'b1011;
    exp_gnt_q.push_back(0);
    push_rsp(0, ~mats[0], 1'b0, 1'b0);
    do_reset();
    wait_gnts("t6_gnt0");
    req_valid = '0;
    drain("t6_rsp");
    for (int n = 0; n < 20; n++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
